// File: rtl/braille_chord_capture_pkg.sv
// braille_pkg: shared constants and FSM state type for the chord capture block
package braille_pkg;
  localparam int DOTS = 6;
  typedef enum logic [2:0] {IDLE, ACCUM, EMIT, ABORT, WAIT_REL} state_t;
endpackage

// File: rtl/braille_key_debounce.sv
// braille_key_debounce: 2-flop sync plus ms-tick debounce for one active-low key
module braille_key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1ms,
  input  logic raw_n,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw_n};
      if (sync[1] == level) cnt <= '0;
      else if (tick_1ms) begin
        cnt   <= (cnt == CW'(DEBOUNCE_MS - 1)) ? '0 : cnt + 1'b1;
        level <= (cnt == CW'(DEBOUNCE_MS - 1)) ? sync[1] : level;
      end
    end
  assign pressed = ~level;
endmodule

// File: rtl/braille_chord_capture.sv
// braille_chord_capture: debounce six keys, accumulate a chord and report it with its hold time
module braille_chord_capture
  import braille_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int MAX_HOLD_MS = 2000,
  parameter int HOLD_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1ms,
  input  logic [5:0]        keys_n,
  output logic [5:0]        chord,
  output logic              chord_valid,
  output logic [HOLD_W-1:0] hold_ms,
  output logic              hold_timeout,
  output logic              busy
);
  if (MAX_HOLD_MS >= 2 ** HOLD_W) begin : g_bad_hold
    $error("MAX_HOLD_MS must be below 2**HOLD_W so hcnt cannot wrap");
  end
  logic [DOTS-1:0] pressed, acc;
  logic [HOLD_W-1:0] hcnt;
  state_t st;
  for (genvar d = 0; d < DOTS; d++) begin : g_key
    braille_key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .raw_n(keys_n[d]), .pressed(pressed[d])
    );
  end
  always_ff @(posedge clk)
    if (!rst) begin
      st           <= IDLE;
      acc          <= '0;
      hcnt         <= '0;
      chord        <= '0;
      chord_valid  <= 1'b0;
      hold_ms      <= '0;
      hold_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      chord_valid  <= 1'b0;
      hold_timeout <= 1'b0;
      case (st)
        IDLE: begin
          acc  <= pressed;
          hcnt <= '0;
          st   <= |pressed ? ACCUM : IDLE;
          busy <= |pressed;
        end
        ACCUM: begin
          acc  <= acc | pressed;
          hcnt <= hcnt + HOLD_W'(tick_1ms);
          // release wins over timeout when both happen together
          st   <= ~|pressed ? EMIT : (hcnt == HOLD_W'(MAX_HOLD_MS)) ? ABORT : ACCUM;
        end
        EMIT: begin
          chord       <= acc;
          hold_ms     <= hcnt;
          chord_valid <= 1'b1;
          st          <= IDLE;
          busy        <= 1'b0;
        end
        ABORT: begin
          hold_timeout <= 1'b1;
          st           <= WAIT_REL;
        end
        WAIT_REL: begin
          st   <= |pressed ? WAIT_REL : IDLE;
          busy <= |pressed;
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
